// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: single-button sequencer that owns the board ALU operand, opcode and result
// registers. Three debounced presses of enter load A, B and the opcode. The block then spends
// one settle cycle in EXEC, captures the ALU result and holds it in SHOW until the next enter
// press. A cancel press abandons a partly entered sequence.
//
// Ports:
//   i_clk, i_reset    clock and synchronous active-high reset
//   i_switch          operand/opcode value from the board switches
//   i_btn_enter       raw asynchronous enter button (active-high)
//   i_btn_cancel      raw asynchronous cancel button (active-high)
//   i_alu_result      combinational result from the ALU
//   o_a, o_b          registered operands driven to the ALU
//   o_opcode          registered opcode driven to the ALU
//   o_result          captured ALU result for the LEDs
//   o_result_valid    high while in SHOW
//   o_state           current sequencer state for the LEDs
module alu_seq_ctrl #(
  parameter int unsigned NB_DATA         = 8,
  parameter int unsigned NB_OPCODE       = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NB_DBCNT        = 20
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NB_DATA-1:0]   i_switch,
  input  logic                 i_btn_enter,
  input  logic                 i_btn_cancel,
  input  logic [NB_DATA-1:0]   i_alu_result,
  output logic [NB_DATA-1:0]   o_a,
  output logic [NB_DATA-1:0]   o_b,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_result_valid,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    StLoadA  = 3'd0,
    StLoadB  = 3'd1,
    StLoadOp = 3'd2,
    StExec   = 3'd3,
    StShow   = 3'd4
  } state_e;

  // Button index 0 is enter, index 1 is cancel; both get identical conditioning.
  localparam int unsigned NumBtn = 2;
  localparam logic [NB_DBCNT-1:0] CntLast = NB_DBCNT'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_DBCNT-1:0] CntOne  = NB_DBCNT'(1);

  logic [NumBtn-1:0] btn_raw;

  logic [NumBtn-1:0]               meta_q;
  logic [NumBtn-1:0]               sync_q;
  logic [NumBtn-1:0]               level_q, level_d;
  logic [NumBtn-1:0]               level_dly_q;
  logic [NumBtn-1:0]               pulse_q;
  logic [NumBtn-1:0]               block_q, block_d;
  logic [NumBtn-1:0]               hold_meta_q;
  logic [NumBtn-1:0][NB_DBCNT-1:0] cnt_q, cnt_d;
  logic [1:0]                      vld_q;

  logic enter_pulse;
  logic cancel_pulse;

  state_e state_q, state_d;

  logic load_a;
  logic load_b;
  logic load_op;
  logic capture;

  logic [NB_DATA-1:0]   a_q;
  logic [NB_DATA-1:0]   b_q;
  logic [NB_OPCODE-1:0] opcode_q;
  logic [NB_DATA-1:0]   result_q;

  assign btn_raw = {i_btn_cancel, i_btn_enter};

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------

  // Samples the raw buttons even while reset is asserted, so that a button held across reset
  // can be recognised. It needs no reset: its value is only consumed during reset, by which
  // time it holds a real sample.
  always_ff @(posedge i_clk) begin
    hold_meta_q <= btn_raw;
  end

  always_comb begin
    level_d = level_q;
    block_d = block_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < NumBtn; i++) begin
      if (block_q[i]) begin
        // The button was held through reset. The level stays low, and the counter instead
        // measures a stable release. Samples taken before the synchroniser has refilled after
        // reset are not trusted.
        if (!vld_q[1] || sync_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntLast) begin
          block_d[i] = 1'b0;
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end else if (sync_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        level_d[i] = ~level_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q      <= '0;
      sync_q      <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      pulse_q     <= '0;
      cnt_q       <= '0;
      vld_q       <= '0;
      block_q     <= hold_meta_q;
    end else begin
      meta_q      <= btn_raw;
      sync_q      <= meta_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pulse_q     <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
      vld_q       <= {vld_q[0], 1'b1};
      block_q     <= block_d;
    end
  end

  assign enter_pulse  = pulse_q[0];
  assign cancel_pulse = pulse_q[1];

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StLoadA;
    end else begin
      state_q <= state_d;
    end
  end

  // Cancel takes priority wherever it is honoured. In LOAD_A it is ignored, and EXEC always
  // completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StLoadA: begin
        if (enter_pulse) state_d = StLoadB;
      end
      StLoadB: begin
        if (cancel_pulse)     state_d = StLoadA;
        else if (enter_pulse) state_d = StLoadOp;
      end
      StLoadOp: begin
        if (cancel_pulse)     state_d = StLoadA;
        else if (enter_pulse) state_d = StExec;
      end
      StExec: state_d = StShow;
      StShow: begin
        if (cancel_pulse || enter_pulse) state_d = StLoadA;
      end
      default: state_d = StLoadA;
    endcase
  end

  always_comb begin
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    capture = 1'b0;
    case (state_q)
      StLoadA:  load_a  = enter_pulse;
      StLoadB:  load_b  = enter_pulse & ~cancel_pulse;
      StLoadOp: load_op = enter_pulse & ~cancel_pulse;
      StExec:   capture = 1'b1;
      default:  ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand, opcode and result registers
  // ---------------------------------------------------------------------------

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_q      <= '0;
      b_q      <= '0;
      opcode_q <= '0;
      result_q <= '0;
    end else begin
      if (load_a)  a_q      <= i_switch;
      if (load_b)  b_q      <= i_switch;
      if (load_op) opcode_q <= i_switch[NB_OPCODE-1:0];
      // The ALU sees only the registered operands, so the result is independent of the switches.
      if (capture) result_q <= i_alu_result;
    end
  end

  assign o_a            = a_q;
  assign o_b            = b_q;
  assign o_opcode       = opcode_q;
  assign o_result       = result_q;
  assign o_result_valid = (state_q == StShow);
  assign o_state        = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a short debounce window.
module tb_alu_seq_ctrl;

  localparam int unsigned Dbc  = 4;
  localparam int unsigned Hold = Dbc + 8;
  localparam int unsigned Idle = Dbc + 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       btn_en = 1'b0;
  logic       btn_ca = 1'b0;
  logic [7:0] alu_res;
  logic [7:0] o_a, o_b, o_result;
  logic [5:0] o_opcode;
  logic       o_valid;
  logic [2:0] o_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Bench ALU
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return {a[3:0], b[7:4]};
    endcase
  endfunction

  assign alu_res = alu_fn(o_a, o_b, o_opcode);

  alu_seq_ctrl #(
    .NB_DATA(8),
    .NB_OPCODE(6),
    .DEBOUNCE_CYCLES(Dbc),
    .NB_DBCNT(8)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_switch(sw),
    .i_btn_enter(btn_en),
    .i_btn_cancel(btn_ca),
    .i_alu_result(alu_res),
    .o_a(o_a),
    .o_b(o_b),
    .o_opcode(o_opcode),
    .o_result(o_result),
    .o_result_valid(o_valid),
    .o_state(o_state)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    btn_en = 1'b0;
    btn_ca = 1'b0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
  endtask

  // Clean press: the button(s) rise together, stay stable well past the debounce window, then
  // release with a long quiet period.
  task automatic press(input logic en, input logic ca, input logic [7:0] s);
    sw = s;
    btn_en = en;
    btn_ca = ca;
    cyc(Hold);
    btn_en = 1'b0;
    btn_ca = 1'b0;
    cyc(Idle);
  endtask

  task automatic test_reset();
    sw = 8'hA5;
    rst = 1'b1;
    cyc(3);
    n_checks++; if (o_a !== 8'h00) begin n_fail++; $display("FAIL reset_a: got %h want 00", o_a); end
    n_checks++; if (o_b !== 8'h00) begin n_fail++; $display("FAIL reset_b: got %h want 00", o_b); end
    n_checks++; if (o_opcode !== 6'h00) begin n_fail++; $display("FAIL reset_op: got %h want 00", o_opcode); end
    n_checks++; if (o_result !== 8'h00) begin n_fail++; $display("FAIL reset_res: got %h want 00", o_result); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", o_state); end
  endtask

  // Enter rises before edge 0; the load must appear after edge 7 and not before.
  task automatic test_press_latency();
    sw = 8'h15;
    btn_en = 1'b1;
    rst = 1'b0;
    cyc(7);
    n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL lat_early_state: got %0d want 0", o_state); end
    n_checks++; if (o_a !== 8'h00) begin n_fail++; $display("FAIL lat_early_a: got %h want 00", o_a); end
    cyc(1);
    n_checks++; if (o_state !== 3'd1) begin n_fail++; $display("FAIL lat_state: got %0d want 1", o_state); end
    n_checks++; if (o_a !== 8'h15) begin n_fail++; $display("FAIL lat_a: got %h want 15", o_a); end
    cyc(Hold);
    btn_en = 1'b0;
    cyc(Idle);
    n_checks++; if (o_state !== 3'd1) begin n_fail++; $display("FAIL lat_hold_state: got %0d want 1", o_state); end
  endtask

  task automatic test_full_sequence();
    bit found;
    apply_reset();
    press(1'b1, 1'b0, 8'h0F);
    n_checks++; if (o_a !== 8'h0F) begin n_fail++; $display("FAIL seq_a: got %h want 0f", o_a); end
    press(1'b1, 1'b0, 8'h01);
    n_checks++; if (o_b !== 8'h01) begin n_fail++; $display("FAIL seq_b: got %h want 01", o_b); end
    n_checks++; if (o_state !== 3'd2) begin n_fail++; $display("FAIL seq_state_op: got %0d want 2", o_state); end
    sw = 8'h20;
    btn_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (o_state == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL seq_exec_seen: got 0 want 1"); end
    n_checks++; if (o_result !== 8'h00) begin n_fail++; $display("FAIL seq_res_in_exec: got %h want 00", o_result); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL seq_valid_in_exec: got %b want 0", o_valid); end
    cyc(1);
    n_checks++; if (o_state !== 3'd4) begin n_fail++; $display("FAIL seq_show: got %0d want 4", o_state); end
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid: got %b want 1", o_valid); end
    n_checks++; if (o_result !== 8'h10) begin n_fail++; $display("FAIL seq_res: got %h want 10", o_result); end
    n_checks++; if (o_opcode !== 6'h20) begin n_fail++; $display("FAIL seq_op: got %h want 20", o_opcode); end
    cyc(Hold);
    btn_en = 1'b0;
    sw = 8'hEE;
    cyc(Idle);
    n_checks++; if (o_result !== 8'h10) begin n_fail++; $display("FAIL seq_res_held: got %h want 10", o_result); end
    n_checks++; if (o_state !== 3'd4) begin n_fail++; $display("FAIL seq_show_held: got %0d want 4", o_state); end
  endtask

  task automatic test_bounce();
    apply_reset();
    sw = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      btn_en = 1'b1;
      cyc(3);
      btn_en = 1'b0;
      cyc(3);
    end
    n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL bounce_none: got %0d want 0", o_state); end
    btn_en = 1'b1;
    cyc(Hold);
    btn_en = 1'b0;
    cyc(Idle);
    n_checks++; if (o_state !== 3'd1) begin n_fail++; $display("FAIL bounce_state: got %0d want 1", o_state); end
    n_checks++; if (o_a !== 8'h3C) begin n_fail++; $display("FAIL bounce_a: got %h want 3c", o_a); end
  endtask

  task automatic test_enter_cancel_same();
    apply_reset();
    press(1'b1, 1'b0, 8'h11);
    press(1'b1, 1'b0, 8'h22);
    press(1'b1, 1'b0, 8'h22);
    n_checks++; if (o_result !== 8'hEF) begin n_fail++; $display("FAIL both_res_sub: got %h want ef", o_result); end
    press(1'b1, 1'b0, 8'h00);
    press(1'b1, 1'b0, 8'h33);
    press(1'b1, 1'b0, 8'h44);
    press(1'b1, 1'b1, 8'h25);
    n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL both_state: got %0d want 0", o_state); end
    n_checks++; if (o_opcode !== 6'h22) begin n_fail++; $display("FAIL both_op: got %h want 22", o_opcode); end
    n_checks++; if (o_b !== 8'h44) begin n_fail++; $display("FAIL both_b: got %h want 44", o_b); end
  endtask

  task automatic test_reset_held_button();
    apply_reset();
    press(1'b1, 1'b0, 8'h05);
    press(1'b1, 1'b0, 8'h06);
    sw = 8'h24;
    btn_en = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2 * Dbc + 10);
    n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL rsthold_state: got %0d want 0", o_state); end
    n_checks++; if (o_a !== 8'h00) begin n_fail++; $display("FAIL rsthold_a: got %h want 00", o_a); end
    n_checks++; if (o_b !== 8'h00) begin n_fail++; $display("FAIL rsthold_b: got %h want 00", o_b); end
    n_checks++; if (o_opcode !== 6'h00) begin n_fail++; $display("FAIL rsthold_op: got %h want 00", o_opcode); end
    btn_en = 1'b0;
    cyc(Idle);
    n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL rsthold_release: got %0d want 0", o_state); end
    press(1'b1, 1'b0, 8'h77);
    n_checks++; if (o_state !== 3'd1) begin n_fail++; $display("FAIL rsthold_repress: got %0d want 1", o_state); end
    n_checks++; if (o_a !== 8'h77) begin n_fail++; $display("FAIL rsthold_a2: got %h want 77", o_a); end
  endtask

  task automatic test_cancel_show();
    apply_reset();
    press(1'b1, 1'b0, 8'h0F);
    press(1'b1, 1'b0, 8'h01);
    press(1'b1, 1'b0, 8'h20);
    press(1'b0, 1'b1, 8'h00);
    n_checks++; if (o_state !== 3'd0) begin n_fail++; $display("FAIL cshow_state: got %0d want 0", o_state); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL cshow_valid: got %b want 0", o_valid); end
    n_checks++; if (o_result !== 8'h10) begin n_fail++; $display("FAIL cshow_res: got %h want 10", o_result); end
    press(1'b1, 1'b0, 8'h99);
    n_checks++; if (o_a !== 8'h99) begin n_fail++; $display("FAIL cshow_a: got %h want 99", o_a); end
    n_checks++; if (o_result !== 8'h10) begin n_fail++; $display("FAIL cshow_res2: got %h want 10", o_result); end
  endtask

  // Random press/cancel/glitch traffic against an abstract sequencer model.
  task automatic test_random();
    int         stage;
    logic [7:0] ma, mb, mres, s;
    logic [5:0] mop;
    logic [5:0] ops [6];
    int         kind;
    bit         en, ca;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    apply_reset();
    stage = 0;
    ma = 8'h00;
    mb = 8'h00;
    mop = 6'h00;
    mres = 8'h00;
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 5));
      s = ($urandom_range(0, 1) == 1) ? {2'b00, ops[$urandom_range(0, 5)]} : 8'($urandom);
      en = (kind <= 1) || (kind == 3);
      ca = (kind == 2) || (kind == 3);
      if (kind >= 4) begin
        sw = s;
        if (kind == 4) btn_en = 1'b1;
        else           btn_ca = 1'b1;
        cyc(int'($urandom_range(1, Dbc - 1)));
        btn_en = 1'b0;
        btn_ca = 1'b0;
        cyc(Idle);
      end else begin
        press(en, ca, s);
        if (ca && (stage == 1 || stage == 2 || stage == 4)) begin
          stage = 0;
        end else if (en) begin
          case (stage)
            0: begin ma = s; stage = 1; end
            1: begin mb = s; stage = 2; end
            2: begin mop = s[5:0]; mres = alu_fn(ma, mb, mop); stage = 4; end
            default: stage = 0;
          endcase
        end
      end
      n_checks++; if (o_state !== 3'(stage)) begin n_fail++; $display("FAIL rnd_state op%0d: got %0d want %0d", n, o_state, stage); end
      n_checks++; if (o_a !== ma) begin n_fail++; $display("FAIL rnd_a op%0d: got %h want %h", n, o_a, ma); end
      n_checks++; if (o_b !== mb) begin n_fail++; $display("FAIL rnd_b op%0d: got %h want %h", n, o_b, mb); end
      n_checks++; if (o_opcode !== mop) begin n_fail++; $display("FAIL rnd_op op%0d: got %h want %h", n, o_opcode, mop); end
      n_checks++; if (o_result !== mres) begin n_fail++; $display("FAIL rnd_res op%0d: got %h want %h", n, o_result, mres); end
      n_checks++; if (o_valid !== (stage == 4)) begin n_fail++; $display("FAIL rnd_valid op%0d: got %b want %b", n, o_valid, (stage == 4)); end
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_full_sequence();
    test_bounce();
    test_enter_cancel_same();
    test_reset_held_button();
    test_cancel_show();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Button-driven sequencer that owns the operand, opcode and result registers of the board-level ALU. An operator sets the switches and presses one enter button three times to load operand A, operand B and the opcode. The block then captures the combinational ALU result and holds it for display. It sits between the raw board buttons/switches and the ALU instance, replacing per-register load buttons with debounced single-button sequencing.

## Interface

Parameters:
- NB_DATA, 8, operand/result width; also the switch width
- NB_OPCODE, 6, opcode width; must be <= NB_DATA
- DEBOUNCE_CYCLES, 1000000, stable cycles required before a button level is accepted; must be >= 2
- NB_DBCNT, 20, debounce counter width; must satisfy 2^NB_DBCNT > DEBOUNCE_CYCLES

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_switch  in  NB_DATA  operand/opcode value from the board switches
- i_btn_enter  in  1  raw, asynchronous enter button, active-high
- i_btn_cancel  in  1  raw, asynchronous cancel button, active-high
- i_alu_result  in  NB_DATA  combinational result from the ALU
- o_a  out  NB_DATA  operand A to the ALU
- o_b  out  NB_DATA  operand B to the ALU
- o_opcode  out  NB_OPCODE  opcode to the ALU
- o_result  out  NB_DATA  captured result, for the LEDs
- o_result_valid  out  1  high while in SHOW
- o_state  out  3  current FSM state, for the LEDs

## Operation

Button conditioning is identical for each button:
- 2-flop synchronizer.
- Debounce: the counter clears whenever the synced value equals the debounced level, and increments otherwise. When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced level toggles and the counter clears.
- The press pulse is a registered rising edge of the debounced level: high exactly 1 cycle per press. Release produces no pulse.

FSM states and o_state encoding: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4. Encodings 5–7 are illegal and return to LOAD_A on the next cycle.

Transitions:
- LOAD_A + enter: o_a <= i_switch; go to LOAD_B.
- LOAD_B + enter: o_b <= i_switch; go to LOAD_OP.
- LOAD_OP + enter: o_opcode <= i_switch[NB_OPCODE-1:0]; go to EXEC.
- EXEC: unconditionally, o_result <= i_alu_result; go to SHOW. This is one settle cycle with the new opcode applied.
- SHOW + enter: go to LOAD_A. o_a, o_b, o_opcode and o_result are all held.
- Cancel pulse in LOAD_B, LOAD_OP or SHOW: go to LOAD_A. No register changes.
- Cancel pulse in LOAD_A or EXEC: ignored. EXEC always completes.
- Enter and cancel pulses in the same cycle: cancel wins where it is honoured. Where cancel is ignored, enter acts normally (LOAD_A loads A).

Registers change only on the transitions listed. The result is always captured from the registered operands, never from live switches. o_result_valid = (state == SHOW).

## Timing

- Reset values: o_a, o_b, o_opcode, o_result = 0; o_result_valid = 0; o_state = LOAD_A. Synchronizer, debounce counters, debounced levels and pulse registers all clear.
- Reset mid-sequence discards all loaded values. A button still held when reset releases must first be seen released by the debouncer, then pressed again, before it produces a pulse.
- Press latency: raw button rises before edge 0 and stays stable → press pulse high in cycle DEBOUNCE_CYCLES+3. The register load and state change are visible one cycle later.
- Glitch rejection: a raw pulse or bounce shorter than DEBOUNCE_CYCLES synced cycles produces no pulse.
- Result latency: opcode load edge → EXEC for 1 cycle → o_result updated and o_result_valid high on the following edge.
- One press advances at most one state.

## Test plan

1. DEBOUNCE_CYCLES=4. Hold reset for 3 cycles → all outputs 0, o_state=0. Hold enter high from cycle 0 with i_switch=8'h15 → pulse at cycle 7; o_a=8'h15 and o_state=1 at cycle 8.
2. Full sequence with A=8'h0F, B=8'h01, opcode=6'h20, bench ALU model = add → o_result=8'h10, o_result_valid=1, o_state=4. Change i_switch afterwards → o_result still 8'h10.
3. Enter bounce: 3-cycle high/low toggles, then held steady → exactly one pulse; state advances by exactly one.
4. In LOAD_OP, press enter and cancel in the same cycle → o_state=0; o_opcode unchanged.
5. Assert i_reset while in LOAD_OP, with enter still held through reset release → all outputs 0; no load until enter is released and pressed again.
6. In SHOW, press cancel → LOAD_A with o_result retained. Press enter in LOAD_A → o_a loads and o_result stays unchanged until the next EXEC.
